// File: rtl/clock_pkg.sv
// Shared constants for the time-of-day digit chain sequencer.
// Holds the set-mode encoding, digit index map and the FSM state type.
package clock_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  // Digit positions within en/done, least significant first.
  localparam int unsigned D_SU = 0;
  localparam int unsigned D_ST = 1;
  localparam int unsigned D_MU = 2;
  localparam int unsigned D_MT = 3;
  localparam int unsigned D_HU = 4;
  localparam int unsigned D_HT = 5;

  // Values presented on the mode output.
  localparam logic [1:0] MODE_RUN = 2'd0;
  localparam logic [1:0] MODE_SEC = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;
  localparam logic [1:0] MODE_HR  = 2'd3;

  // State encoding equals the mode encoding so mode is the state register.
  typedef enum logic [1:0] {
    ST_RUN = MODE_RUN,
    ST_SEC = MODE_SEC,
    ST_MIN = MODE_MIN,
    ST_HR  = MODE_HR
  } state_e;

endpackage

// File: rtl/tick_divider.sv
// Enable-gated, clearable modulo-TERM tick counter.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous load of zero (wins over en)
//   en           : advance the count by one
//   term_c       : high in the cycle whose en completes a group of TERM
module tick_divider #(
  parameter int unsigned TERM = 1,
  parameter int unsigned W    = $clog2(TERM + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic term_c
);

  logic [W-1:0] count_q;
  logic         last_c;

  assign last_c = (count_q == W'(TERM - 1));
  assign term_c = en & ~clr & last_c;

  // Wrapping counter; term_c marks the wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= last_c ? '0 : count_q + W'(1);
    end
  end

endmodule

// File: rtl/clock_chain_ctrl.sv
// Time-of-day digit chain sequencer: turns the 1 Hz tick into per-digit
// count enables with ripple carry, handles the 23:59:59 wrap, emits the day
// carry and runs the time-set FSM (field select, blink, inactivity timeout).
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   tick                : 1 Hz single-cycle strobe
//   mode_btn, inc_btn   : debounced single-cycle button pulses
//   done[5:0]           : per-digit terminal flags (level)
//   hr_wrap             : hours display 23 (level)
//   en[5:0]             : per-digit single-cycle count enables
//   clr_hr              : single-cycle clear of both hour digits
//   day_tick            : single-cycle carry to the date stage
//   mode                : 0=RUN 1=SET_SEC 2=SET_MIN 3=SET_HR
//   blink               : blank request for the selected field
//   running             : high in RUN
module clock_chain_ctrl
  import clock_pkg::*;
#(
  parameter  int unsigned BLINK_TICKS = 1,
  parameter  int unsigned SET_TIMEOUT = 60,
  localparam int unsigned TO_W        = $clog2(SET_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  mode_btn,
  input  logic                  inc_btn,
  input  logic [NUM_DIGITS-1:0] done,
  input  logic                  hr_wrap,
  output logic [NUM_DIGITS-1:0] en,
  output logic                  clr_hr,
  output logic                  day_tick,
  output logic [1:0]            mode,
  output logic                  blink,
  output logic                  running
);

  localparam int unsigned BL_W = $clog2(BLINK_TICKS + 1);

  state_e                state_q, state_d;
  logic [NUM_DIGITS-1:0] en_d;
  logic                  clr_hr_d;
  logic                  day_tick_d;
  logic                  carry4_c;
  logic                  expired_q;
  logic                  set_active_c;
  logic                  change_c;
  logic                  to_clr_c;
  logic                  to_term_c;
  logic                  bl_clr_c;
  logic                  bl_term_c;
  logic                  done_ht_unused;

  // Hour-tens terminal flag is not needed: hr_wrap covers the 23 rollover.
  assign done_ht_unused = done[D_HT];

  assign mode         = state_q;
  assign set_active_c = (state_q != ST_RUN);
  assign change_c     = (state_d != state_q);
  assign to_clr_c     = ~set_active_c | change_c | mode_btn | inc_btn;
  assign bl_clr_c     = ~set_active_c | change_c | inc_btn;

  // Inactivity timeout: counts ticks since the last press or state entry.
  tick_divider #(.TERM(SET_TIMEOUT), .W(TO_W)) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (to_clr_c),
    .en     (tick & set_active_c),
    .term_c (to_term_c)
  );

  // Blink phase divider for the selected field.
  tick_divider #(.TERM(BLINK_TICKS), .W(BL_W)) u_blink (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (bl_clr_c),
    .en     (tick & set_active_c),
    .term_c (bl_term_c)
  );

  // Next-state and event decode.
  always_comb begin
    state_d    = state_q;
    en_d       = '0;
    clr_hr_d   = 1'b0;
    day_tick_d = 1'b0;
    carry4_c   = &done[D_MT:D_SU];
    case (state_q)
      ST_RUN: begin
        if (tick) begin
          en_d[D_SU] = 1'b1;
          en_d[D_ST] = done[D_SU];
          en_d[D_MU] = &done[D_ST:D_SU];
          en_d[D_MT] = &done[D_MU:D_SU];
          if (carry4_c && hr_wrap) begin
            clr_hr_d   = 1'b1;
            day_tick_d = 1'b1;
          end else begin
            en_d[D_HU] = carry4_c;
            en_d[D_HT] = carry4_c & done[D_HU];
          end
        end
        if (mode_btn) state_d = ST_SEC;
      end
      ST_SEC: begin
        if (mode_btn) begin
          state_d = ST_MIN;
        end else if (expired_q) begin
          state_d = ST_RUN;
        end else if (inc_btn) begin
          en_d[D_SU] = 1'b1;
          en_d[D_ST] = done[D_SU];
        end
      end
      ST_MIN: begin
        if (mode_btn) begin
          state_d = ST_HR;
        end else if (expired_q) begin
          state_d = ST_RUN;
        end else if (inc_btn) begin
          en_d[D_MU] = 1'b1;
          en_d[D_MT] = done[D_MU];
        end
      end
      ST_HR: begin
        if (mode_btn || expired_q) begin
          state_d = ST_RUN;
        end else if (inc_btn) begin
          if (hr_wrap) begin
            clr_hr_d = 1'b1;
          end else begin
            en_d[D_HU] = 1'b1;
            en_d[D_HT] = done[D_HU];
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      en        <= '0;
      clr_hr    <= 1'b0;
      day_tick  <= 1'b0;
      expired_q <= 1'b0;
      blink     <= 1'b0;
      running   <= 1'b1;
    end else begin
      state_q   <= state_d;
      en        <= en_d;
      clr_hr    <= clr_hr_d;
      day_tick  <= day_tick_d;
      expired_q <= to_term_c;
      blink     <= bl_clr_c ? 1'b0 : (blink ^ bl_term_c);
      running   <= (state_d == ST_RUN);
    end
  end

endmodule
